// File: rtl/bus_cycle_sequencer_if.sv
// Request, status and bus-pin signals between the bus-cycle sequencer and its neighbours.
// master = the sequencer, slave = request front-end / pin drivers / bus model.
interface bus_cycle_sequencer_if #(
  parameter int BURST_MAX = 4,
  parameter int TIMEOUT_W = 8
);
  localparam int LEN_W = $clog2(BURST_MAX) + 1;

  logic                 activate;
  logic [LEN_W-1:0]     burst_len;
  logic [TIMEOUT_W-1:0] timeout_limit;
  logic                 as_feedback;
  logic                 latch;
  logic                 berr;
  logic                 mc_clk_rising;

  logic [3:0]           state;
  logic                 busy;
  logic                 drive_bus;
  logic                 drive_as;
  logic                 drive_ds;
  logic                 do_latch;
  logic [LEN_W-1:0]     beat_idx;
  logic                 done;
  logic [1:0]           err;

  modport master (
    input  activate, burst_len, timeout_limit, as_feedback, latch, berr, mc_clk_rising,
    output state, busy, drive_bus, drive_as, drive_ds, do_latch, beat_idx, done, err
  );

  modport slave (
    output activate, burst_len, timeout_limit, as_feedback, latch, berr, mc_clk_rising,
    input  state, busy, drive_bus, drive_as, drive_ds, do_latch, beat_idx, done, err
  );
endinterface

// File: rtl/bus_cycle_sequencer.sv
// Registered 68k-style bus-cycle sequencer: one request runs a burst of bus cycles with
// setup stretch, AS/DSACK timeout and BERR abort. All outputs are Moore decodes.
//
// state      | meaning
// -----------+----------------------------------------------------------
// WAIT       | idle, sampling activate
// ACTIVATE   | request accepted, length captured
// SETUP_BUS  | address/FC driven, setup stretch (SETUP_CYCLES clocks)
// DRIVE_AS   | AS asserted, waiting for AS feedback
// DRIVE_DS   | DS asserted
// WAIT_DSACK | waiting for DSACK (latch)
// LATCH      | read data captured this clock
// CLEAR_AS   | strobes released
// ON_DSACK   | waiting for AS low on a 68k clock rising edge
// FINALIZE   | next beat or request done
// ERROR      | aborted (BERR/timeout), drives off until bus idle
module bus_cycle_sequencer #(
  parameter int BURST_MAX    = 4,
  parameter int SETUP_CYCLES = 1,
  parameter int TIMEOUT_W    = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  bus_cycle_sequencer_if.master bus
);
  localparam int LEN_W   = $clog2(BURST_MAX) + 1;
  localparam int SETUP_W = $clog2(SETUP_CYCLES + 1);

  localparam logic [1:0] ERR_OK      = 2'd0;
  localparam logic [1:0] ERR_BERR    = 2'd1;
  localparam logic [1:0] ERR_TIMEOUT = 2'd2;

  typedef enum logic [3:0] {
    ST_WAIT       = 4'd0,
    ST_ACTIVATE   = 4'd1,
    ST_SETUP_BUS  = 4'd2,
    ST_DRIVE_AS   = 4'd3,
    ST_DRIVE_DS   = 4'd4,
    ST_WAIT_DSACK = 4'd5,
    ST_LATCH      = 4'd6,
    ST_CLEAR_AS   = 4'd7,
    ST_ON_DSACK   = 4'd8,
    ST_FINALIZE   = 4'd9,
    ST_ERROR      = 4'd10
  } state_t;

  state_t               state_q, state_d;
  logic [LEN_W-1:0]     len_q, len_d;
  logic [LEN_W-1:0]     beat_q, beat_d;
  logic [SETUP_W-1:0]   setup_q, setup_d;
  logic [TIMEOUT_W-1:0] tmo_q, tmo_d;
  logic [1:0]           err_q, err_d;
  logic                 done_q, done_d;

  logic [LEN_W-1:0]     len_clamped;
  logic [LEN_W-1:0]     beat_next;
  logic                 tmo_hit;
  logic                 bus_idle_edge;

  always_comb begin
    len_clamped = bus.burst_len;
    if (bus.burst_len == '0)
      len_clamped = LEN_W'(1);
    else if (bus.burst_len > LEN_W'(BURST_MAX))
      len_clamped = LEN_W'(BURST_MAX);
  end

  assign beat_next     = beat_q + LEN_W'(1);
  assign tmo_hit       = (bus.timeout_limit != '0) &&
                         (tmo_q == bus.timeout_limit - TIMEOUT_W'(1));
  assign bus_idle_edge = !bus.as_feedback && bus.mc_clk_rising;

  // Abort priority in the strobe states: BERR, then timeout, then normal progress.
  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    beat_d  = beat_q;
    err_d   = err_q;
    done_d  = 1'b0;
    case (state_q)
      ST_WAIT: begin
        if (bus.activate) begin
          state_d = ST_ACTIVATE;
          len_d   = len_clamped;
          beat_d  = '0;
          err_d   = ERR_OK;
        end
      end
      ST_ACTIVATE:  state_d = ST_SETUP_BUS;
      ST_SETUP_BUS: if (setup_q == '0) state_d = ST_DRIVE_AS;
      ST_DRIVE_AS: begin
        if (bus.berr) begin
          state_d = ST_ERROR;
          err_d   = ERR_BERR;
        end else if (tmo_hit) begin
          state_d = ST_ERROR;
          err_d   = ERR_TIMEOUT;
        end else if (bus.as_feedback) begin
          state_d = ST_DRIVE_DS;
        end
      end
      ST_DRIVE_DS: begin
        if (bus.berr) begin
          state_d = ST_ERROR;
          err_d   = ERR_BERR;
        end else begin
          state_d = ST_WAIT_DSACK;
        end
      end
      ST_WAIT_DSACK: begin
        if (bus.berr) begin
          state_d = ST_ERROR;
          err_d   = ERR_BERR;
        end else if (tmo_hit) begin
          state_d = ST_ERROR;
          err_d   = ERR_TIMEOUT;
        end else if (bus.latch) begin
          state_d = ST_LATCH;
        end
      end
      ST_LATCH:    state_d = ST_CLEAR_AS;
      ST_CLEAR_AS: state_d = ST_ON_DSACK;
      ST_ON_DSACK: if (bus_idle_edge) state_d = ST_FINALIZE;
      ST_FINALIZE: begin
        if (beat_next < len_q) begin
          state_d = ST_SETUP_BUS;
          beat_d  = beat_next;
        end else begin
          state_d = ST_WAIT;
          done_d  = 1'b1;
        end
      end
      ST_ERROR: begin
        if (bus_idle_edge) begin
          state_d = ST_WAIT;
          done_d  = 1'b1;
        end
      end
      default: state_d = ST_WAIT;
    endcase
  end

  // Setup stretch is a down-counter loaded on entry, exit on terminal count.
  always_comb begin
    setup_d = setup_q;
    if (state_d == ST_SETUP_BUS && state_q != ST_SETUP_BUS)
      setup_d = SETUP_W'(SETUP_CYCLES - 1);
    else if (state_q == ST_SETUP_BUS && setup_q != '0)
      setup_d = setup_q - SETUP_W'(1);
  end

  always_comb begin
    tmo_d = tmo_q;
    if (state_d != state_q)
      tmo_d = '0;
    else if ((state_q == ST_DRIVE_AS || state_q == ST_WAIT_DSACK) && tmo_q != '1)
      tmo_d = tmo_q + TIMEOUT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_WAIT;
      len_q   <= '0;
      beat_q  <= '0;
      setup_q <= '0;
      tmo_q   <= '0;
      err_q   <= ERR_OK;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      beat_q  <= beat_d;
      setup_q <= setup_d;
      tmo_q   <= tmo_d;
      err_q   <= err_d;
      done_q  <= done_d;
    end
  end

  assign bus.state     = state_q;
  assign bus.busy      = (state_q != ST_WAIT) && (state_q <= ST_ERROR);
  assign bus.drive_bus = (state_q >= ST_SETUP_BUS) && (state_q <= ST_LATCH);
  assign bus.drive_as  = (state_q >= ST_DRIVE_AS)  && (state_q <= ST_LATCH);
  assign bus.drive_ds  = (state_q >= ST_DRIVE_DS)  && (state_q <= ST_LATCH);
  assign bus.do_latch  = (state_q == ST_LATCH);
  assign bus.beat_idx  = beat_q;
  assign bus.done      = done_q;
  assign bus.err       = err_q;
endmodule

// File: tb/tb_bus_cycle_sequencer.sv
// Self-checking bench for bus_cycle_sequencer: a small bus responder drives AS/DSACK/BERR
// while expected beat indices and request status are queued and checked as the DUT reports them.
module tb_bus_cycle_sequencer;
  localparam int BURST_MAX    = 4;
  localparam int SETUP_CYCLES = 2;
  localparam int TW           = 8;
  localparam int LEN_W        = $clog2(BURST_MAX) + 1;

  localparam int ST_WAIT       = 0;
  localparam int ST_ACTIVATE   = 1;
  localparam int ST_SETUP_BUS  = 2;
  localparam int ST_DRIVE_AS   = 3;
  localparam int ST_DRIVE_DS   = 4;
  localparam int ST_WAIT_DSACK = 5;
  localparam int ST_LATCH      = 6;
  localparam int ST_ERROR      = 10;

  logic clk;
  logic rst;
  int   n_pass;
  int   n_chk;
  int   mc_div;
  int   exp_beat_q[$];
  int   exp_err_q[$];

  bus_cycle_sequencer_if #(.BURST_MAX(BURST_MAX), .TIMEOUT_W(TW)) ifc ();

  bus_cycle_sequencer #(
    .BURST_MAX   (BURST_MAX),
    .SETUP_CYCLES(SETUP_CYCLES),
    .TIMEOUT_W   (TW)
  ) dut (
    .clk  (clk),
    .reset(rst),
    .bus  (ifc.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp)
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    else
      n_pass++;
  endtask

  function automatic logic [31:0] outs();
    return 32'({ifc.state, ifc.busy, ifc.drive_bus, ifc.drive_as, ifc.drive_ds,
                ifc.do_latch, ifc.beat_idx, ifc.done, ifc.err});
  endfunction

  task automatic bus_quiet();
    ifc.activate      = 1'b0;
    ifc.as_feedback   = 1'b0;
    ifc.latch         = 1'b0;
    ifc.berr          = 1'b0;
    ifc.mc_clk_rising = 1'b0;
  endtask

  // latch_dly = 0 means DSACK never arrives; berr_at = 0 means no bus error.
  task automatic run_req(input int len, input int limit, input int as_dly, input int latch_dly,
                         input int berr_at, input int rst_beat, input bit junk_act);
    int       exp_err, n_beats, as_cnt, ds_cnt, setup_run, prev;
    bit       fin;
    logic [3:0] st;
    n_beats = (len == 0) ? 1 : ((len > BURST_MAX) ? BURST_MAX : len);
    if (berr_at > 0)         exp_err = 1;
    else if (latch_dly == 0) exp_err = 2;
    else                     exp_err = 0;
    if (exp_err == 0)
      for (int i = 0; i < n_beats; i++) exp_beat_q.push_back(i);
    exp_err_q.push_back(exp_err);

    @(negedge clk);
    ifc.activate      = 1'b1;
    ifc.burst_len     = LEN_W'(len);
    ifc.timeout_limit = TW'(limit);
    @(negedge clk);
    ifc.activate = 1'b0;
    chk("start_busy", 32'(ifc.busy), 32'(1));
    chk("start_state", 32'(ifc.state), 32'(ST_ACTIVATE));

    as_cnt = 0; ds_cnt = 0; setup_run = 0; prev = ST_ACTIVATE; fin = 1'b0;
    for (int cyc = 0; cyc < 400 && !fin; cyc++) begin
      @(negedge clk);
      st = ifc.state;
      mc_div++;
      if (ifc.do_latch) begin
        chk("latch_drives", 32'({ifc.drive_bus, ifc.drive_as, ifc.drive_ds}), 32'(7));
        if (exp_beat_q.size() == 0) chk("latch_extra", 32'(ifc.do_latch), 32'(0));
        else                        chk("beat_idx", 32'(ifc.beat_idx), 32'(exp_beat_q.pop_front()));
      end
      if (int'(st) == ST_SETUP_BUS) setup_run++;
      else if (prev == ST_SETUP_BUS) begin
        chk("setup_len", 32'(setup_run), 32'(SETUP_CYCLES));
        setup_run = 0;
      end
      if (int'(st) == ST_ERROR && prev != ST_ERROR) begin
        chk("err_drives", 32'({ifc.drive_bus, ifc.drive_as, ifc.drive_ds, ifc.do_latch}), 32'(0));
        if (exp_err == 2) chk("tmo_clocks", 32'(ds_cnt), 32'(limit));
      end
      if (ifc.done) begin
        if (exp_err_q.size() == 0) chk("done_extra", 32'(ifc.done), 32'(0));
        else                       chk("err", 32'(ifc.err), 32'(exp_err_q.pop_front()));
        chk("done_busy", 32'(ifc.busy), 32'(0));
        chk("done_state", 32'(ifc.state), 32'(ST_WAIT));
        fin = 1'b1;
      end
      if (!fin && rst_beat >= 0 && int'(st) == ST_WAIT_DSACK && int'(ifc.beat_idx) == rst_beat) begin
        rst = 1'b1;
        bus_quiet();
        @(negedge clk);
        rst = 1'b0;
        chk("rst_outs", outs(), 32'(0));
        repeat (3) @(negedge clk);
        chk("rst_idle", outs(), 32'(0));
        exp_beat_q.delete();
        exp_err_q.delete();
        fin = 1'b1;
      end
      if (!fin) begin
        ifc.activate      = junk_act && (int'(st) == ST_SETUP_BUS);
        ifc.mc_clk_rising = (mc_div % 3 == 0);
        ifc.latch         = 1'b0;
        ifc.berr          = 1'b0;
        if (int'(st) == ST_DRIVE_AS) begin
          as_cnt++;
          ifc.as_feedback = (as_cnt >= as_dly);
        end else if (int'(st) == ST_DRIVE_DS || int'(st) == ST_WAIT_DSACK || int'(st) == ST_LATCH) begin
          ifc.as_feedback = 1'b1;
        end else begin
          ifc.as_feedback = 1'b0;
          as_cnt = 0;
        end
        if (int'(st) == ST_WAIT_DSACK) begin
          ds_cnt++;
          ifc.latch = (latch_dly > 0) && (ds_cnt >= latch_dly);
          ifc.berr  = (berr_at > 0) && (ds_cnt >= berr_at);
        end else if (int'(st) != ST_ERROR) begin
          ds_cnt = 0;
        end
      end
      prev = int'(st);
    end
    chk("req_finished", 32'(fin), 32'(1));
    bus_quiet();
    repeat (4) @(negedge clk);
    chk("idle_state", 32'(ifc.state), 32'(ST_WAIT));
    chk("beats_left", 32'(exp_beat_q.size()), 32'(0));
    if (rst_beat < 0) chk("err_hold", 32'(ifc.err), 32'(exp_err));
  endtask

  initial begin
    n_pass = 0;
    n_chk  = 0;
    mc_div = 0;
    rst    = 1'b1;
    bus_quiet();
    ifc.burst_len     = '0;
    ifc.timeout_limit = '0;
    repeat (3) @(negedge clk);
    chk("reset_outs", outs(), 32'(0));
    rst = 1'b0;
    @(negedge clk);
    chk("post_reset_state", 32'(ifc.state), 32'(ST_WAIT));

    //       len lim as lat berr rst junk
    run_req(1,  0,  2, 3,  0,  -1, 1'b0);
    run_req(3,  0,  2, 3,  0,  -1, 1'b1);
    run_req(0,  0,  1, 1,  0,  -1, 1'b0);
    run_req(7,  0,  2, 2,  0,  -1, 1'b0);
    run_req(2,  5,  2, 3,  0,  -1, 1'b0);
    run_req(2,  5,  2, 0,  0,  -1, 1'b0);
    run_req(1,  0,  2, 3,  3,  -1, 1'b0);
    run_req(3,  0,  2, 3,  0,   1, 1'b0);
    run_req(2,  0,  3, 2,  0,  -1, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
